bios_rom_arbiter: RTL
=====================

# bios_rom_arbiter

Two-master Wishbone arbiter that shares the single-ported BIOS ROM slave between master 0 (CPU instruction/data bus) and master 1 (boot shadow-copy / debug master). It grants one master at a time, holds the grant for the whole Wishbone cycle, and masks the ROM's stale registered acknowledge after each release. It sits between the bus address decoder's BIOS chip-select outputs and the BIOS ROM core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: stall limit for a granted strobe with no ack; used only when the timeout feature is compiled in; range 1..255.

Ports (one line per master pair; `mX` means m0 and m1):
- wb_clk_i  in  1  system clock, all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- mX_adr_i  in  19 [19:1] word address from master X
- mX_dat_i  in  16 write data from master X (forwarded; ROM ignores it)
- mX_dat_o  out 16 read data to master X
- mX_we_i / mX_tga_i  in  1 each  write enable / tag, forwarded from the granted master
- mX_sel_i  in  2  byte selects
- mX_stb_i / mX_cyc_i  in  1 each  strobe / cycle from master X
- mX_ack_o  out 1  ack to master X
- mX_err_o  out 1  timeout error to master X (constant 0 without the feature)
- s_adr_o, s_dat_o, s_we_o, s_tga_o, s_sel_o  out 19/16/1/1/2  muxed from the granted master
- s_stb_o / s_cyc_o  out 1 each  to ROM
- s_dat_i / s_ack_i  in  16/1  from ROM

## Operation
- States: IDLE, GNT0, GNT1, DRAIN.
- IDLE: s_cyc_o = s_stb_o = 0. A request is mX_cyc_i & mX_stb_i.
  - One requester: go to GNTX.
  - Both requesting: grant the master not served last (`last` pointer). `last` resets to 1, so m0 wins the first tie.
- GNTX:
  - s_cyc_o = mX_cyc_i, s_stb_o = mX_stb_i; address, control and write data come from master X.
  - mX_ack_o = s_ack_i; mX_dat_o = s_dat_i. The other master's ack and err are 0.
  - The grant is held while mX_cyc_i = 1, so multi-beat cycles are not broken.
  - When mX_cyc_i drops: set last = X and go to DRAIN.
- DRAIN: exactly one cycle. s_cyc_o = s_stb_o = 0 and all acks are masked, which absorbs the ROM's registered ack left over from the last strobe. Then go to IDLE.
- mX_dat_o is driven with s_dat_i for both masters at all times; only the ack qualifies it.
- Reset mid-cycle: state = IDLE, last = 1, timer = 0. All outputs go to 0 on the next edge and the pending transfer is dropped with no ack.

## Timing
- Request in IDLE at edge n: grant is registered at n+1, s_stb_o is high during cycle n+1, ROM ack arrives at n+2, and mX_ack_o is high during n+2.
- Single-transfer latency is 2 cycles from stb to ack.
- A master holding stb after its ack receives an ack every cycle; this is pipelined sequential reads at 1 word/cycle.
- Turnaround from cyc dropping to the next grant is 2 cycles (DRAIN, then IDLE), so the earliest next s_stb_o is 3 cycles after release.
- The losing master is not starved: round-robin guarantees a grant at the next release.
- Reset values: every output 0, state IDLE.

## Configuration
- BIOS_ARB_TIMEOUT_EN defined:
  - An 8-bit timer counts cycles in GNTX with s_stb_o = 1 and s_ack_i = 0; it clears on ack or on leaving GNTX.
  - When the count reaches TIMEOUT_CYCLES, mX_err_o pulses high for one cycle, mX_ack_o stays 0, and the state is forced to DRAIN with last = X.
- BIOS_ARB_TIMEOUT_EN undefined: no timer is built, mX_err_o is tied to 0, and the grant is held indefinitely.

## Structure
- Shared package zbc_wb_pkg holds:
  - the state encoding enum (IDLE, GNT0, GNT1, DRAIN)
  - WB_ADR_W = 19 and WB_DAT_W = 16
  - the default timeout constant
- Natural sub-module: arb_rr2, the two-way round-robin pick. Inputs are req[1:0] and last; output is the grant index. It is purely combinational; the arbiter holds the registered state.

## Test plan
- Single read: m0 reads adr 0x00010 with ROM word 0x1234. Expect s_stb_o at cycle 1, m0_ack_o at cycle 2 with m0_dat_o = 0x1234; m1_ack_o stays 0.
- Simultaneous request after reset: m0 and m1 both request at cycle 0. m0 is served first. m1 is granted 2 cycles after m0 drops cyc, and m1 receives exactly one ack.
- Stale ack masked: m0 drops cyc the cycle after its ack while the ROM ack is still high. No ack reaches m0 or m1 during DRAIN.
- Burst hold: m1 keeps cyc/stb high for 4 addresses while m0 requests. m1 gets 4 consecutive acks, then m0 is granted.
- Timeout (macro on, TIMEOUT_CYCLES = 5, ROM ack stuck at 0): m0_err_o pulses at the 5th stalled cycle, then DRAIN, then IDLE. Macro off: no err, and the grant is held.
- Reset mid-grant: assert wb_rst_i during GNT1. All outputs are 0 next cycle, and the following tie goes to m0.

Source files
------------

// File: rtl/zbc_wb_pkg.sv
// Shared Wishbone definitions for the BIOS ROM arbiter: bus widths, arbiter
// state encoding and the default stall-timeout limit.
package zbc_wb_pkg;

    localparam int WB_ADR_W        = 19;
    localparam int WB_DAT_W        = 16;
    localparam int WB_SEL_W        = 2;
    localparam int TIMER_W         = 8;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: returns the index of the master to grant,
// preferring the one that was not served last when both request.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    always_comb begin
        // NOTE: default first so every path assigns gnt and no latch is inferred.
        gnt = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/bios_rom_arbiter.sv
// Two-master Wishbone arbiter in front of the single-ported BIOS ROM.
// Optional stall timeout is compiled in with `define BIOS_ARB_TIMEOUT_EN.
module bios_rom_arbiter
    import zbc_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,

    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    input  logic                m0_we_i,
    input  logic                m0_tga_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic                m0_stb_i,
    input  logic                m0_cyc_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,

    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    input  logic                m1_we_i,
    input  logic                m1_tga_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic                m1_stb_i,
    input  logic                m1_cyc_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,

    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    output logic                s_we_o,
    output logic                s_tga_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic                s_stb_o,
    output logic                s_cyc_o,
    input  logic [WB_DAT_W-1:0] s_dat_i,
    input  logic                s_ack_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("bios_rom_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] req;
    logic       pick;
    logic       timeout;

    assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    arb_rr2 u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (pick)
    );

    // Read data is broadcast; only the per-master ack qualifies it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

`ifdef BIOS_ARB_TIMEOUT_EN
    logic [TIMER_W-1:0] timer_q;
    logic               stalled;

    assign stalled = (((state_q == GNT0) && m0_stb_i) ||
                      ((state_q == GNT1) && m1_stb_i)) && !s_ack_i;
    assign timeout = stalled && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            timer_q <= '0;
        else if (stalled && (state_d != DRAIN))
            timer_q <= timer_q + 1'b1;
        else
            timer_q <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_tga_o  = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req)
                    state_d = pick ? GNT1 : GNT0;
            end
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_tga_o  = m0_tga_i;
                s_sel_o  = m0_sel_i;
                s_stb_o  = m0_stb_i;
                s_cyc_o  = m0_cyc_i;
                // A registered ack landing after the master dropped cyc is stale.
                m0_ack_o = s_ack_i & m0_cyc_i;
                m0_err_o = timeout;
                if (!m0_cyc_i || timeout) begin
                    state_d = DRAIN;
                    last_d  = 1'b0;
                end
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_tga_o  = m1_tga_i;
                s_sel_o  = m1_sel_i;
                s_stb_o  = m1_stb_i;
                s_cyc_o  = m1_cyc_i;
                m1_ack_o = s_ack_i & m1_cyc_i;
                m1_err_o = timeout;
                if (!m1_cyc_i || timeout) begin
                    state_d = DRAIN;
                    last_d  = 1'b1;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
